generador_verificador_trafico: RTL and testbench

- Synthesizable, parametrised traffic generator and self-checker for the PCIe transaction-layer router (main FIFO -> VC FIFOs -> destination FIFOs).
- Replaces the fixed, hand-timed push/pop stimulus sequence with an FSM that does four things:
  - sequences init;
  - pushes a configurable burst while honouring Pausa_MF;
  - drains every destination with pop;
  - checks each popped word against a per-channel expected queue.
- Drives the DUT directly. It works in simulation and on the FPGA bring-up board.

---
 rtl/generador_verificador_trafico_pkg.sv | 41 ++++
 rtl/generador_verificador_trafico_if.sv | 42 ++++
 rtl/generador_verificador_trafico_cola_esperada.sv | 51 +++++
 rtl/generador_verificador_trafico.sv | 194 +++++++++++++++++++
 tb/tb_generador_verificador_trafico.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/generador_verificador_trafico_pkg.sv
// Shared types and helpers for the router traffic generator/checker.
// Word layout is {vc, dest, payload} with vc in the MSB.
package gen_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_INIT,
    S_SETTLE,
    S_PUSH,
    S_DRAIN,
    S_DONE,
    S_FAIL
  } state_e;

  localparam int LFSR_W = 4;
  // x^4 + x^3 + 1, maximal length
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

  function automatic int calc_dest_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  function automatic int vc_bit(input int dw);
    return dw - 1;
  endfunction

  function automatic int dest_lsb(input int dw, input int destw);
    return dw - 1 - destw;
  endfunction

  function automatic int payload_w(input int dw, input int destw);
    return dw - 1 - destw;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/generador_verificador_trafico_if.sv
// Signal bundle between the traffic generator and the router.
// master = generator side, slave = router side.
interface generador_verificador_trafico_if #(
  parameter int DATA_W = 6,
  parameter int N_CH   = 2
);

  logic                     init;
  logic [DATA_W-1:0]        data_in_principal;
  logic                     push;
  logic [N_CH-1:0]          pop;
  logic                     Pausa_MF;
  logic                     active_out;
  logic                     idle_out;
  logic                     error_out;
  logic [N_CH*DATA_W-1:0]   data_out;

  modport master (
    output init,
    output data_in_principal,
    output push,
    output pop,
    input  Pausa_MF,
    input  active_out,
    input  idle_out,
    input  error_out,
    input  data_out
  );

  modport slave (
    input  init,
    input  data_in_principal,
    input  push,
    input  pop,
    output Pausa_MF,
    output active_out,
    output idle_out,
    output error_out,
    output data_out
  );

endinterface

// File: rtl/generador_verificador_trafico_cola_esperada.sv
// Expected-word FIFO, one per destination channel.
// A push and a pop in the same cycle leave occupancy unchanged.
module cola_esperada #(
  parameter int DW    = 6,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_L || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/generador_verificador_trafico.sv
// Traffic generator and self-checker for the PCIe TL router:
// init, burst push, round-robin drain, per-channel compare.
module generador_verificador_trafico
  import gen_pkg::*;
#(
  parameter int              DATA_W    = 6,
  parameter int              N_CH      = 2,
  parameter int              BURST_LEN = 8,
  parameter int              EXP_DEPTH = 8,
  parameter int              POP_LAT   = 1,
  parameter int              TIMEOUT   = 255,
  parameter logic [LFSR_W-1:0] SEED    = 4'hA
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       start,
  generador_verificador_trafico_if.master bus,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam int DEST_W    = calc_dest_w(N_CH);
  localparam int VC_BIT    = vc_bit(DATA_W);
  localparam int DEST_LSB  = dest_lsb(DATA_W, DEST_W);
  localparam int PAYLOAD_W = payload_w(DATA_W, DEST_W);
  localparam int TMR_W     = $clog2(TIMEOUT + 1);
  localparam int CNT_W     = $clog2(EXP_DEPTH) + 1;

  state_e                        state_q, state_d;
  logic [LFSR_W-1:0]             lfsr_q;
  logic [7:0]                    idx_q;
  logic [TMR_W-1:0]              tmr_q;
  logic [DATA_W-1:0]             hold_q;
  logic [7:0]                    err_q;
  logic [DEST_W-1:0]             rr_q;
  logic [POP_LAT-1:0][N_CH-1:0]  pipe_q;
  logic [N_CH-1:0][1:0]          infl_q;

  logic [DATA_W-1:0]             word_w;
  logic [DEST_W-1:0]             dest_sel;
  logic [DEST_W-1:0]             cand_w;
  logic [DEST_W-1:0]             sel_w;
  logic                          found_w;
  logic                          push_w;
  logic                          init_w;
  logic                          progress_w;
  logic                          active_w;
  logic                          start_acc_w;
  logic                          flush_w;
  logic [N_CH-1:0]               pop_w;
  logic [N_CH-1:0]               full_w;
  logic [N_CH-1:0]               empty_w;
  logic [N_CH-1:0]               deq_w;
  logic [N_CH-1:0]               miss_w;
  logic [N_CH-1:0]               avail_w;
  logic [N_CH-1:0][DATA_W-1:0]   head_w;
  logic [N_CH-1:0][CNT_W-1:0]    cnt_w;
  logic                          unused_active;

  assign unused_active = bus.active_out;

  assign active_w = state_q inside {S_INIT, S_SETTLE, S_PUSH, S_DRAIN};
  assign start_acc_w = start && (state_q inside {S_WAIT, S_DONE, S_FAIL});
  assign flush_w  = (state_q == S_INIT);
  assign deq_w    = pipe_q[POP_LAT-1];
  assign progress_w = push_w || (|deq_w);

  always_comb begin
    dest_sel = DEST_W'(int'(lfsr_q[DEST_W:1]) % N_CH);
    word_w = '0;
    word_w[VC_BIT] = lfsr_q[0];
    word_w[DEST_LSB +: DEST_W] = dest_sel;
    word_w[PAYLOAD_W-1:0] = PAYLOAD_W'(idx_q);
  end

  always_comb begin
    miss_w  = '0;
    avail_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      avail_w[i] = cnt_w[i] > CNT_W'(infl_q[i]);
      miss_w[i]  = deq_w[i] &&
        (bus.data_out[i*DATA_W +: DATA_W] != head_w[i]);
    end
  end

  // Round robin from rr_q; lowest offset wins.
  always_comb begin
    found_w = 1'b0;
    sel_w   = '0;
    cand_w  = '0;
    pop_w   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      cand_w = DEST_W'((int'(rr_q) + j) % N_CH);
      if (avail_w[cand_w]) begin
        found_w = 1'b1;
        sel_w   = cand_w;
      end
    end
    if (state_q == S_DRAIN && !bus.error_out && found_w)
      pop_w[sel_w] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    push_w  = 1'b0;
    init_w  = 1'b0;
    unique case (state_q)
      S_WAIT: if (start) state_d = S_INIT;
      S_INIT: begin
        init_w  = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (bus.idle_out) state_d = S_PUSH;
      S_PUSH: begin
        push_w = !bus.Pausa_MF && !full_w[dest_sel];
        if (push_w && idx_q == 8'(BURST_LEN - 1))
          state_d = S_DRAIN;
      end
      S_DRAIN: if (&empty_w) state_d = S_DONE;
      S_DONE, S_FAIL: if (start) state_d = S_INIT;
      default: state_d = S_WAIT;
    endcase
    if (active_w && (bus.error_out ||
        (state_d == state_q && !(push_w || (|deq_w)) &&
         tmr_q == TMR_W'(TIMEOUT))))
      state_d = S_FAIL;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= S_WAIT;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      tmr_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      rr_q    <= '0;
      pipe_q  <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || progress_w) tmr_q <= '0;
      else if (tmr_q != TMR_W'(TIMEOUT)) tmr_q <= tmr_q + 1'b1;
      if (flush_w) idx_q <= '0;
      else if (push_w) idx_q <= idx_q + 1'b1;
      if (push_w) begin
        lfsr_q <= lfsr_next(lfsr_q);
        hold_q <= word_w;
      end
      if (start_acc_w) err_q <= '0;
      else if (|miss_w && !flush_w && err_q != 8'hFF)
        err_q <= err_q + 1'b1;
      if (flush_w) begin
        pipe_q <= '0;
        infl_q <= '0;
      end else begin
        pipe_q[0] <= pop_w;
        for (int i = 1; i < POP_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        for (int i = 0; i < N_CH; i++)
          infl_q[i] <= infl_q[i] + {1'b0, pop_w[i]} - {1'b0, deq_w[i]};
      end
      if (|pop_w)
        rr_q <= (int'(sel_w) == N_CH - 1) ? '0 : sel_w + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cola
    cola_esperada #(
      .DW    (DATA_W),
      .DEPTH (EXP_DEPTH)
    ) u_cola (
      .clk     (clk),
      .reset_L (reset_L),
      .flush_i (flush_w),
      .push_i  (push_w && (int'(dest_sel) == g)),
      .data_i  (word_w),
      .pop_i   (deq_w[g]),
      .data_o  (head_w[g]),
      .full_o  (full_w[g]),
      .empty_o (empty_w[g]),
      .count_o (cnt_w[g])
    );
  end

  assign bus.init              = init_w;
  assign bus.push              = push_w;
  assign bus.pop               = pop_w;
  assign bus.data_in_principal = push_w ? word_w : hold_q;
  assign done      = (state_q == S_DONE) || (state_q == S_FAIL);
  assign pass      = (state_q == S_DONE) && (err_q == 8'd0);
  assign err_count = err_q;

endmodule

// File: tb/tb_generador_verificador_trafico.sv
// Directed bench: behavioural router model plus hand-computed vectors.
module tb_generador_verificador_trafico;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic       pass;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // SEED=A, taps x^4+x^3+1: words {vc,dest,idx}
  localparam logic [5:0] EXP_W [8] = '{
    6'h10, 6'h21, 6'h32, 6'h33, 6'h34, 6'h15, 6'h06, 6'h07
  };

  generador_verificador_trafico_if #(.DATA_W(6), .N_CH(2)) bus ();

  generador_verificador_trafico dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .start     (start),
    .bus       (bus),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  logic [5:0] q0 [$];
  logic [5:0] q1 [$];
  logic [5:0] pushed [$];
  int push_cnt;
  int pop_cnt;
  int init_cnt;
  int ch1_pops;
  int corrupt_idx = -1;

  always @(posedge clk) begin
    logic [5:0] v;
    if (!reset_L) begin
      q0.delete();
      q1.delete();
      pushed.delete();
      push_cnt = 0;
      pop_cnt  = 0;
      init_cnt = 0;
      ch1_pops = 0;
      bus.data_out <= '0;
    end else begin
      if (bus.init) init_cnt++;
      if (bus.push) begin
        pushed.push_back(bus.data_in_principal);
        push_cnt++;
        if (bus.data_in_principal[4]) q1.push_back(bus.data_in_principal);
        else q0.push_back(bus.data_in_principal);
      end
      if (bus.pop[0] && q0.size() > 0) begin
        bus.data_out[5:0] <= q0.pop_front();
        pop_cnt++;
      end
      if (bus.pop[1] && q1.size() > 0) begin
        v = q1.pop_front();
        if (ch1_pops == corrupt_idx) v = v ^ 6'h01;
        ch1_pops++;
        pop_cnt++;
        bus.data_out[11:6] <= v;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_push(input int n, input int budget);
    int c = 0;
    while (push_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("push_reached", 32'(push_cnt), 32'(n));
  endtask

  initial begin
    bus.Pausa_MF   = 1'b0;
    bus.active_out = 1'b0;
    bus.idle_out   = 1'b1;
    bus.error_out  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_push", 32'(bus.push), 32'd0);
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_init", 32'(bus.init), 32'd0);
    chk("rst_data", 32'(bus.data_in_principal), 32'd0);
    reset_L = 1'b1;

    // clean run
    pulse_start();
    chk("t1_init_hi", 32'(bus.init), 32'd1);
    wait_done(100);
    chk("t1_init_cnt", 32'(init_cnt), 32'd1);
    chk("t1_push_cnt", 32'(push_cnt), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_word%0d", i),
          32'((i < pushed.size()) ? pushed[i] : 6'bx), 32'(EXP_W[i]));
    chk("t1_pop_cnt", 32'(pop_cnt), 32'd8);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_err", 32'(err_count), 32'd0);

    // Pausa_MF held 5 cycles after 3 pushes
    do_reset();
    pulse_start();
    wait_push(3, 50);
    bus.Pausa_MF = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_push_lo", 32'(bus.push), 32'd0);
      chk("t2_data_hold", 32'(bus.data_in_principal), 32'h32);
      @(negedge clk);
    end
    chk("t2_cnt_frozen", 32'(push_cnt), 32'd3);
    bus.Pausa_MF = 1'b0;
    wait_done(100);
    chk("t2_push_cnt", 32'(push_cnt), 32'd8);
    chk("t2_word3", 32'((pushed.size() > 3) ? pushed[3] : 6'bx), 32'h33);
    chk("t2_pass", 32'(pass), 32'd1);

    // second word on channel 1 corrupted
    do_reset();
    corrupt_idx = 1;
    pulse_start();
    wait_done(100);
    chk("t3_err", 32'(err_count), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_pop_cnt", 32'(pop_cnt), 32'd8);
    corrupt_idx = -1;

    // error_out during drain
    do_reset();
    pulse_start();
    begin
      int c = 0;
      while (bus.pop == 2'b00 && c < 100) begin
        @(negedge clk);
        c++;
      end
    end
    chk("t4_in_drain", 32'(bus.pop != 2'b00), 32'd1);
    bus.error_out = 1'b1;
    @(negedge clk);
    chk("t4_pop", 32'(bus.pop), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    bus.error_out = 1'b0;

    // idle_out never rises: fail after TIMEOUT+1 settle cycles
    bus.idle_out = 1'b0;
    do_reset();
    pulse_start();
    repeat (256) @(negedge clk);
    chk("t5_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_pass", 32'(pass), 32'd0);
    bus.idle_out = 1'b1;

    // reset for one cycle mid-burst, then a clean run
    do_reset();
    pulse_start();
    wait_push(4, 50);
    reset_L = 1'b0;
    @(negedge clk);
    chk("t6_push", 32'(bus.push), 32'd0);
    chk("t6_pop", 32'(bus.pop), 32'd0);
    chk("t6_init", 32'(bus.init), 32'd0);
    chk("t6_data", 32'(bus.data_in_principal), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(err_count), 32'd0);
    reset_L = 1'b1;
    pulse_start();
    wait_done(100);
    chk("t6_push_cnt", 32'(push_cnt), 32'd8);
    chk("t6_word0", 32'((pushed.size() > 0) ? pushed[0] : 6'bx), 32'h10);
    chk("t6_word7", 32'((pushed.size() > 7) ? pushed[7] : 6'bx), 32'h07);
    chk("t6_pop_cnt", 32'(pop_cnt), 32'd8);
    chk("t6_pass", 32'(pass), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
